branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//   Dynamic branch predictor for the 5-stage RISC-V pipeline; produces the branch prediction consumed by the ID-stage control unit.
//   - IF stage: indexes a table of 2-bit saturating counters with the fetch PC and gives a taken/not-taken prediction to the PC mux.
//   - ID stage: presents the prediction, aligned with the IF/ID register, as pred_taken_id.
//   - ID-stage resolution (branch outcome) updates the table and the mispredict statistics.
// PARAMETERS
//   PC_W   64  width of program counter
//   IDX_W  4   table index bits; table has 2**IDX_W counters
//   STAT_W 32  width of statistics counters
// PORTS
//   clk            in   1      clock, rising edge
//   arst           in   1      asynchronous reset, active-high
//   fetch_pc       in   PC_W   PC of instruction in IF
//   pred_taken     out  1      combinational prediction for fetch_pc (counter MSB)
//   if_id_en       in   1      IF/ID register enable (0 = hazard stall)
//   flush          in   1      IF/ID flush (mispredict or jump)
//   pred_taken_id  out  1      registered prediction of the instruction in ID (to control unit)
//   upd_valid      in   1      instruction in ID is a conditional branch being resolved
//   upd_taken      in   1      actual outcome (register compare equal)
//   mispredict     out  1      comb: upd_valid & id_valid & (upd_taken != pred_taken_id)
//   stat_branches  out  STAT_W resolved branch count
//   stat_mispred   out  STAT_W mispredicted branch count
// BEHAVIOUR
//   Reset (async, arst=1): all counters = 2'b01 (weakly not-taken); pred_taken_id=0; idx_id=0; id_valid=0; stats=0; ghr=0.
//   Index: lookup idx = fetch_pc[IDX_W+1:2] (XOR ghr when enabled). pred_taken = table[idx][1].
//   ID pipeline regs (pred_taken_id, idx_id, id_valid), per edge, in priority order:
//     - flush=1: pred_taken_id<=0, id_valid<=0 (flush beats stall).
//     - else if if_id_en=1: pred_taken_id<=pred_taken, idx_id<=idx, id_valid<=1.
//     - else: hold.
//   Update commit = upd_valid & id_valid & if_id_en. Upd_valid is ignored during a stall; the control re-presents it on the release cycle.
//   On commit, table[idx_id] is updated (indexed by the stored idx_id, not by a PC):
//     - taken: 00->01->10->11, saturating at 11.
//     - not taken: 11->10->01->00, saturating at 00.
//   Simultaneous commit and flush in the same cycle: both occur. The update uses the pre-flush idx_id.
//   Same-cycle lookup of the entry being updated returns the OLD value (no bypass). The new value is visible the next cycle.
//   Stats: each commit increments stat_branches; commit & mispredict also increments stat_mispred. Both saturate at all-ones.
//   Latency: prediction is 0 cycles (comb). Table update is visible 1 cycle after the commit edge.
//   Reset mid-operation restores all reset values immediately. No state persists.
// CONFIGURATION
//   BP_GSHARE_EN defined:
//     - An IDX_W-bit global history register ghr is added, reset to 0.
//     - Lookup idx = fetch_pc[IDX_W+1:2] ^ ghr.
//     - On commit: ghr <= {ghr[IDX_W-2:0], upd_taken}.
//     - idx_id captures the XORed index.
//   Not defined: no ghr; bimodal indexing by PC only.
//   Ports are identical in both builds.
// STRUCTURE
//   bp_pkg:
//     - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
//     - reset counter value CNT_RST=WNT;
//     - function sat_next(cnt, taken).
//   One sub-module: bp_sat_counter (STAT_W saturating event counter with async reset). It is instantiated twice, for the two stats.
//   Counter table is a flop array (async reset required, so no RAM).
// TESTING
//   1 Reset, then fetch_pc=0x40:
//       pred_taken=0, pred_taken_id=0, stats=0.
//   2 Branch at 0x40 resolved taken 3x (commit each):
//       counter 01->10->11->11; pred_taken=1 from 2nd lookup; stat_branches=3, stat_mispred=1.
//   3 Alias: PCs 0x40 and 0x80 share idx 0 (IDX_W=4):
//       training 0x40 taken makes 0x80 predict taken (bimodal build).
//   4 if_id_en=0 with upd_valid=1 for 2 cycles, then 1:
//       exactly one update; pred_taken_id held during stall.
//   5 flush=1 and commit same cycle:
//       table updated, stat_branches+1, next pred_taken_id=0, id_valid=0 so next upd_valid ignored.
//   6 BP_GSHARE_EN: outcomes T,N,T give ghr=4'b0101; fetch_pc=0x40 indexes entry 5.

Source files
------------

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor:
//   - cnt_e     : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - CNT_RST   : counter value after reset (weakly not-taken)
//   - sat_next  : next counter value for a resolved branch outcome
// -----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_RST = WNT;

    // Move one step towards the outcome, saturating at SNT / ST.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == ST) ? cnt : cnt + 2'd1;
        end else begin
            nxt = (cnt == SNT) ? cnt : cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// W-bit event counter that increments on i_inc and sticks at all-ones.
// Ports:
//   clk      in   1  clock, rising edge
//   arst     in   1  asynchronous reset, active-high (clears the count)
//   i_inc    in   1  count one event this cycle
//   o_count  out  W  current count
// -----------------------------------------------------------------------------
module bp_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Dynamic branch predictor: a table of 2-bit saturating counters indexed by the
// fetch PC gives a combinational prediction in IF; the prediction and its index
// are carried into ID alongside the IF/ID register, and the ID-stage branch
// resolution trains the table and the mispredict statistics.
//
// Build option: define BP_GSHARE_EN to XOR a global history register into the
// table index (gshare). Without it the index is the PC alone (bimodal).
//
// Ports:
//   clk            in   1       clock, rising edge
//   arst           in   1       asynchronous reset, active-high
//   fetch_pc       in   PC_W    PC of the instruction in IF
//   pred_taken     out  1       combinational prediction for fetch_pc
//   if_id_en       in   1       IF/ID register enable (0 = stall)
//   flush          in   1       IF/ID flush
//   pred_taken_id  out  1       prediction of the instruction in ID
//   upd_valid      in   1       ID instruction is a conditional branch resolving
//   upd_taken      in   1       actual branch outcome
//   mispredict     out  1       resolved outcome differs from pred_taken_id
//   stat_branches  out  STAT_W  resolved branch count (saturating)
//   stat_mispred   out  STAT_W  mispredicted branch count (saturating)
// -----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PC_W   = 64,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              pred_taken,
    input  logic              if_id_en,
    input  logic              flush,
    output logic              pred_taken_id,
    input  logic              upd_valid,
    input  logic              upd_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int unsigned Entries = 2 ** IDX_W;

    logic [1:0]       r_table [Entries];
    logic             r_pred_taken_id;
    logic [IDX_W-1:0] r_idx_id;
    logic             r_id_valid;

    logic [IDX_W-1:0] w_pc_idx;
    logic [IDX_W-1:0] w_idx;
    logic             w_commit;
    logic             w_unused_pc;

    assign w_pc_idx    = fetch_pc[IDX_W+1:2];
    assign w_unused_pc = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    assign w_idx = w_pc_idx ^ r_ghr;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ghr <= '0;
        end else if (w_commit) begin
            r_ghr <= {r_ghr[IDX_W-2:0], upd_taken};
        end
    end
`else
    assign w_idx = w_pc_idx;
`endif

    // Table read is the registered value: an entry written this edge still
    // reads its old value until the edge has passed.
    assign pred_taken = r_table[w_idx][1];

    // A stalled ID instruction does not resolve; control re-presents upd_valid
    // on the release cycle, so gating with if_id_en gives exactly one update.
    assign w_commit   = upd_valid & r_id_valid & if_id_en;
    assign mispredict = upd_valid & r_id_valid & (upd_taken != r_pred_taken_id);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < Entries; i++) begin
                r_table[i] <= CNT_RST;
            end
        end else if (w_commit) begin
            // Uses the idx_id present before any same-cycle flush.
            r_table[r_idx_id] <= sat_next(r_table[r_idx_id], upd_taken);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_pred_taken_id <= 1'b0;
            r_idx_id        <= '0;
            r_id_valid      <= 1'b0;
        end else if (flush) begin
            r_pred_taken_id <= 1'b0;
            r_id_valid      <= 1'b0;
        end else if (if_id_en) begin
            r_pred_taken_id <= pred_taken;
            r_idx_id        <= w_idx;
            r_id_valid      <= 1'b1;
        end
    end

    assign pred_taken_id = r_pred_taken_id;

    bp_sat_counter #(
        .W (STAT_W)
    ) u_stat_branches (
        .clk     (clk),
        .arst    (arst),
        .i_inc   (w_commit),
        .o_count (stat_branches)
    );

    bp_sat_counter #(
        .W (STAT_W)
    ) u_stat_mispred (
        .clk     (clk),
        .arst    (arst),
        .i_inc   (w_commit & mispredict),
        .o_count (stat_mispred)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Scoreboard bench: the driver applies one input vector per cycle, asks an
// abstract model (integer counters clamped to 0..3, integer statistics) what
// the outputs must be for that vector, and queues the answer; a monitor pops
// and compares on the falling edge. STAT_W is reduced so the statistics
// saturate within the run.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int PC_W   = 64;
    localparam int IDX_W  = 4;
    localparam int STAT_W = 6;
    localparam int N      = 1 << IDX_W;
    localparam int SMAX   = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [PC_W-1:0]   fetch_pc = '0;
    logic              if_id_en = 1'b0;
    logic              flush = 1'b0;
    logic              upd_valid = 1'b0;
    logic              upd_taken = 1'b0;
    logic              pred_taken;
    logic              pred_taken_id;
    logic              mispredict;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    branch_predictor #(
        .PC_W   (PC_W),
        .IDX_W  (IDX_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .fetch_pc      (fetch_pc),
        .pred_taken    (pred_taken),
        .if_id_en      (if_id_en),
        .flush         (flush),
        .pred_taken_id (pred_taken_id),
        .upd_valid     (upd_valid),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pt;
        int pid;
        int mp;
        int br;
        int ms;
    } exp_t;

    exp_t q[$];

    // Reference model state
    int m_tbl[N];
    int m_pid, m_idx_id, m_idv, m_br, m_ms, m_ghr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_tbl[i] = 1;
        m_pid = 0; m_idx_id = 0; m_idv = 0; m_br = 0; m_ms = 0; m_ghr = 0;
    endtask

    function automatic int model_idx(input logic [PC_W-1:0] pc);
        int i;
        i = int'((pc >> 2) % N);
`ifdef BP_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    // One cycle: apply inputs, queue the outputs they should produce now, then
    // advance the model across the coming rising edge.
    task automatic step(input bit r, input logic [PC_W-1:0] pc, input bit en,
                        input bit fl, input bit uv, input bit ut);
        exp_t e;
        int   idx;
        bit   commit;
        @(posedge clk);
        #1;
        arst = r; fetch_pc = pc; if_id_en = en; flush = fl;
        upd_valid = uv; upd_taken = ut;
        if (r) model_reset();
        idx   = model_idx(pc);
        e.pt  = (m_tbl[idx] >= 2) ? 1 : 0;
        e.pid = m_pid;
        e.mp  = (uv && m_idv != 0 && int'(ut) != m_pid) ? 1 : 0;
        e.br  = m_br;
        e.ms  = m_ms;
        q.push_back(e);
        if (!r) begin
            commit = uv && m_idv != 0 && en;
            if (commit) begin
                if (ut) m_tbl[m_idx_id] = (m_tbl[m_idx_id] < 3) ? m_tbl[m_idx_id] + 1 : 3;
                else    m_tbl[m_idx_id] = (m_tbl[m_idx_id] > 0) ? m_tbl[m_idx_id] - 1 : 0;
                m_br = (m_br < SMAX) ? m_br + 1 : SMAX;
                if (e.mp != 0) m_ms = (m_ms < SMAX) ? m_ms + 1 : SMAX;
                m_ghr = ((m_ghr << 1) | int'(ut)) % N;
            end
            if (fl) begin
                m_pid = 0;
                m_idv = 0;
            end else if (en) begin
                m_pid  = e.pt;
                m_idx_id = idx;
                m_idv  = 1;
            end
        end
    endtask

    // Monitor: every cycle presents a full output vector.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pred_taken",    longint'(pred_taken),    e.pt);
                chk("pred_taken_id", longint'(pred_taken_id), e.pid);
                chk("mispredict",    longint'(mispredict),    e.mp);
                chk("stat_branches", longint'(stat_branches), e.br);
                chk("stat_mispred",  longint'(stat_mispred),  e.ms);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset with PC 0x40 presented
        step(1, 64'h40, 1, 0, 0, 0);
        step(1, 64'h40, 1, 0, 0, 0);
        // Train 0x40 taken three times, with fill cycles between resolutions
        step(0, 64'h40, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 64'h40, 1, 0, 1, 1);
            step(0, 64'h40, 1, 0, 0, 0);
        end
        // Alias 0x80 onto the trained entry
        step(0, 64'h80, 1, 0, 0, 0);
        step(0, 64'h80, 1, 0, 1, 0);
        // Stall with upd_valid held for two cycles, then release
        step(0, 64'h44, 1, 0, 0, 0);
        step(0, 64'h48, 0, 0, 1, 1);
        step(0, 64'h48, 0, 0, 1, 1);
        step(0, 64'h48, 1, 0, 1, 1);
        // Flush and commit together, then an upd_valid that must be ignored
        step(0, 64'h44, 1, 0, 0, 0);
        step(0, 64'h4c, 1, 1, 1, 0);
        step(0, 64'h4c, 1, 0, 1, 1);
        // Gshare history pattern T,N,T on one branch, then lookup 0x40
        step(0, 64'h40, 1, 0, 0, 0);
        step(0, 64'h40, 1, 0, 1, 1);
        step(0, 64'h40, 1, 0, 1, 0);
        step(0, 64'h40, 1, 0, 1, 1);
        step(0, 64'h40, 1, 0, 0, 0);
        // Random phase without resets: drives the stats into saturation
        for (int k = 0; k < 300; k++) begin
            step(0, 64'($urandom_range(0, 255)) << 2, $urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end
        // Reset mid-operation, then random phase with occasional resets
        step(1, 64'h40, 1, 0, 1, 1);
        for (int k = 0; k < 200; k++) begin
            step($urandom_range(0, 99) < 2, 64'($urandom_range(0, 255)) << 2,
                 $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", longint'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
